// File: rtl/data_sram_resp_if.sv
// Initiator-to-SRAM request/response bus.
//
// Handshake: a request transfers on a rising clk edge where req=1 and
// addr_ok=1 (addr, wen, wdata sampled on that edge); addr_ok is not a
// function of req. A response is a single-cycle data_ok pulse; rdata is
// meaningful only while data_ok=1 and reads as zero otherwise. There is no
// backpressure on responses.
interface data_sram_resp_if;
    logic        req;
    logic [3:0]  wen;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic        addr_ok;
    logic        data_ok;
    logic [31:0] rdata;

    modport master (
        output req, wen, addr, wdata,
        input  addr_ok, data_ok, rdata
    );

    modport slave (
        input  req, wen, addr, wdata,
        output addr_ok, data_ok, rdata
    );
endinterface

// File: rtl/data_sram_resp.sv
// Single-port 32-bit word SRAM with a fixed number of wait states per access.
// One access is in flight at a time; a new request can be accepted in the
// response cycle of the previous one. Writes commit on the edge that ends the
// response cycle, so a read accepted in that cycle sees the new bytes.
module data_sram_resp #(
    parameter int ADDR_W      = 10,
    parameter int WAIT_CYCLES = 1
) (
    input  logic             clk,
    input  logic             rst,
    data_sram_resp_if.slave  bus,
    output logic [1:0]       dbgState
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        WAIT = 2'd1,
        RESP = 2'd2
    } state_t;

    localparam logic [3:0] WAIT_LOAD = 4'(WAIT_CYCLES);

    state_t             state;
    state_t             stateNext;
    logic [3:0]         cnt;
    logic [3:0]         cntNext;
    logic               addrOk;
    logic               accept;
    logic               respRead;

    logic [ADDR_W-1:0]  latIdx;
    logic [3:0]         latWen;
    logic [31:0]        latWdata;

    // Storage is deliberately never reset.
    logic [31:0]        mem [0:(1<<ADDR_W)-1];

    // Byte-offset and aliasing upper address bits do not select storage.
    logic               unusedAddrBits;
    assign unusedAddrBits = ^{bus.addr[1:0], bus.addr[31:ADDR_W+2]};

    // Ready in IDLE and RESP; held low while reset is asserted.
    assign addrOk   = !rst && (state == IDLE || state == RESP);
    assign accept   = bus.req && addrOk;
    assign respRead = (state == RESP) && (latWen == 4'b0000);

    assign bus.addr_ok = addrOk;
    assign bus.data_ok = (state == RESP);
    assign bus.rdata   = respRead ? mem[latIdx] : 32'h0;
    assign dbgState    = state;

    // State and wait counter registers.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= IDLE;
            cnt   <= 4'd0;
        end else begin
            state <= stateNext;
            cnt   <= cntNext;
        end
    end

    // Next-state logic: accept from IDLE/RESP, count down in WAIT.
    always_comb begin
        stateNext = state;
        cntNext   = cnt;
        case (state)
            IDLE, RESP: begin
                if (accept) begin
                    stateNext = (WAIT_CYCLES == 0) ? RESP : WAIT;
                    cntNext   = WAIT_LOAD;
                end else begin
                    stateNext = IDLE;
                    cntNext   = 4'd0;
                end
            end
            WAIT: begin
                cntNext = cnt - 4'd1;
                if (cnt <= 4'd1) begin
                    stateNext = RESP;
                end
            end
            default: begin
                stateNext = IDLE;
                cntNext   = 4'd0;
            end
        endcase
    end

    // Capture the accepted request; reset drops any pending access.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            latIdx   <= '0;
            latWen   <= 4'b0000;
            latWdata <= 32'h0;
        end else if (accept) begin
            latIdx   <= bus.addr[ADDR_W+1:2];
            latWen   <= bus.wen;
            latWdata <= bus.wdata;
        end
    end

    // Commit the selected byte lanes on the edge that ends RESP.
    always_ff @(posedge clk) begin
        if (state == RESP) begin
            for (int i = 0; i < 4; i++) begin
                if (latWen[i]) begin
                    mem[latIdx][8*i +: 8] <= latWdata[8*i +: 8];
                end
            end
        end
    end

endmodule
